// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared ASCII constants, emitter states and nibble-to-hex helper
package uart_dbg_pkg;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  typedef enum logic {IDLE, EMIT} state_e;
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/dbg_word_fifo.sv
// dbg_word_fifo: synchronous FIFO with wrap-bit pointers; push is refused when full, pop ignored when empty
module dbg_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = wr_data;
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule

// File: rtl/uart_hex_formatter.sv
// uart_hex_formatter: buffers 32-bit debug words and streams them as uppercase hex ASCII (optional CR LF) over valid/ready
module uart_hex_formatter
  import uart_dbg_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic        busy,
  output logic        overflow
);
  localparam logic [3:0] LAST = APPEND_CRLF ? 4'd9 : 4'd7;
  logic pop, full, empty;
  logic [31:0] head, shift_q, shift_d, shift_n;
  logic [3:0] idx_q, idx_d, idx_n;
  state_e state_q, state_d;
  logic byte_valid_q, byte_valid_d, overflow_q, overflow_d;
  logic [7:0] byte_data_q, byte_data_d;
  dbg_word_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(word_valid),
    .wr_data(word_data),
    .pop(pop),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  assign word_ready = !full;
  assign byte_valid = byte_valid_q;
  assign byte_data = byte_data_q;
  assign overflow = overflow_q;
  assign busy = !empty || (state_q == EMIT);
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d = idx_q;
    byte_valid_d = byte_valid_q;
    byte_data_d = byte_data_q;
    pop = 1'b0;
    overflow_d = overflow_q || (word_valid && full);
    idx_n = idx_q + 4'd1;
    shift_n = idx_q < 4'd8 ? shift_q << 4 : shift_q;
    if (state_q == IDLE && !empty) begin
      pop = 1'b1;
      state_d = EMIT;
      shift_d = head;
      idx_d = '0;
      byte_valid_d = 1'b1;
      byte_data_d = hex_ascii(head[31:28]);
    end else if (state_q == EMIT && byte_ready) begin
      if (idx_q == LAST) begin
        state_d = IDLE;
        byte_valid_d = 1'b0;
      end else begin
        idx_d = idx_n;
        shift_d = shift_n;
        byte_data_d = idx_n == 4'd8 ? ASCII_CR : idx_n == 4'd9 ? ASCII_LF : hex_ascii(shift_n[31:28]);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q <= byte_data_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_uart_hex_formatter.sv
// tb_uart_hex_formatter: directed table-driven bench for the hex formatter (CRLF and no-CRLF instances)
module tb_uart_hex_formatter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic word_valid = 1'b0, word_valid2 = 1'b0;
  logic [31:0] word_data = '0;
  logic byte_ready = 1'b0, byte_ready2 = 1'b0;
  logic word_ready, byte_valid, busy, overflow;
  logic word_ready2, byte_valid2, busy2, overflow2;
  logic [7:0] byte_data, byte_data2;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] w;
    logic [79:0] exp;
  } vec_t;
  vec_t tbl [6];
  uart_hex_formatter dut (
    .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word_data(word_data),
    .word_ready(word_ready), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .busy(busy), .overflow(overflow)
  );
  uart_hex_formatter #(.FIFO_DEPTH(4), .APPEND_CRLF(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .word_valid(word_valid2), .word_data(word_data),
    .word_ready(word_ready2), .byte_valid(byte_valid2), .byte_data(byte_data2),
    .byte_ready(byte_ready2), .busy(busy2), .overflow(overflow2)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic emit_word(input string nm, input logic [79:0] exp, input bit both, input bit push_idle, input logic [31:0] pw);
    byte_ready = 1'b1;
    byte_ready2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_valid%0d", nm, i), byte_valid, 1);
      chk($sformatf("%s_byte%0d", nm, i), byte_data, exp[79-8*i -: 8]);
      if (both && i < 8) begin
        chk($sformatf("%s_nocrlf_valid%0d", nm, i), byte_valid2, 1);
        chk($sformatf("%s_nocrlf_byte%0d", nm, i), byte_data2, exp[79-8*i -: 8]);
      end else if (both && i == 8) begin
        chk($sformatf("%s_nocrlf_stop", nm), byte_valid2, 0);
      end else if (both) begin
        chk($sformatf("%s_nocrlf_busy", nm), busy2, 0);
      end
      @(negedge clk);
    end
    chk($sformatf("%s_gap", nm), byte_valid, 0);
    if (push_idle) begin
      chk($sformatf("%s_gap_ready", nm), word_ready, 1);
      word_valid = 1'b1;
      word_data = pw;
    end
    @(negedge clk);
    word_valid = 1'b0;
  endtask
  initial begin
    logic [79:0] e;
    int k, cyc;
    bit r;
    tbl[0] = '{32'hDEADBEEF, {"DEADBEEF", 8'h0D, 8'h0A}};
    tbl[1] = '{32'h0123ABCD, {"0123ABCD", 8'h0D, 8'h0A}};
    tbl[2] = '{32'h00000000, {"00000000", 8'h0D, 8'h0A}};
    tbl[3] = '{32'hFFFFFFFF, {"FFFFFFFF", 8'h0D, 8'h0A}};
    tbl[4] = '{32'h9A5C3E71, {"9A5C3E71", 8'h0D, 8'h0A}};
    tbl[5] = '{32'h13579BDF, {"13579BDF", 8'h0D, 8'h0A}};
    repeat (2) @(negedge clk);
    chk("rst_word_ready", word_ready, 1);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_data", byte_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst2_word_ready", word_ready2, 1);
    chk("rst2_byte_valid", byte_valid2, 0);
    chk("rst2_overflow", overflow2, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 6; t++) begin
      word_valid = 1'b1;
      word_valid2 = 1'b1;
      word_data = tbl[t].w;
      byte_ready = 1'b1;
      byte_ready2 = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      word_valid2 = 1'b0;
      chk($sformatf("vec%0d_accept_valid", t), byte_valid, 0);
      chk($sformatf("vec%0d_accept_busy", t), busy, 1);
      @(negedge clk);
      emit_word($sformatf("vec%0d", t), tbl[t].exp, 1'b1, 1'b0, 32'h0);
      chk($sformatf("vec%0d_done_busy", t), busy, 0);
      chk($sformatf("vec%0d_done_valid", t), byte_valid, 0);
    end
    e = {"0123ABCD", 8'h0D, 8'h0A};
    word_valid = 1'b1;
    word_data = 32'h0123ABCD;
    @(negedge clk);
    word_valid = 1'b0;
    @(negedge clk);
    k = 0;
    cyc = 0;
    while (k < 10 && cyc < 200) begin
      chk($sformatf("bp_valid%0d", cyc), byte_valid, 1);
      chk($sformatf("bp_byte%0d", cyc), byte_data, e[79-8*k -: 8]);
      r = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      byte_ready = r;
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    chk("bp_all_bytes", k, 10);
    chk("bp_gap", byte_valid, 0);
    byte_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("fill_ready%0d", j), word_ready, j < 5);
      chk($sformatf("fill_overflow%0d", j), overflow, 0);
      word_valid = 1'b1;
      word_data = tbl[j].w;
      @(negedge clk);
    end
    word_valid = 1'b0;
    chk("fill_full_ready", word_ready, 0);
    chk("fill_overflow_set", overflow, 1);
    chk("fill_stalled_valid", byte_valid, 1);
    for (int j = 0; j < 5; j++) emit_word($sformatf("fill%0d", j), tbl[j].exp, 1'b0, 1'b0, 32'h0);
    chk("fill_end_valid", byte_valid, 0);
    chk("fill_end_busy", busy, 0);
    chk("fill_end_ready", word_ready, 1);
    chk("fill_overflow_sticky", overflow, 1);
    word_valid = 1'b1;
    word_data = 32'h12345678;
    @(negedge clk);
    word_valid = 1'b0;
    @(negedge clk);
    chk("rme_byte0", byte_data, 8'h31);
    repeat (3) @(negedge clk);
    chk("rme_byte3", byte_data, 8'h34);
    rst_n = 1'b0;
    #1;
    chk("rme_valid", byte_valid, 0);
    chk("rme_data", byte_data, 8'h00);
    chk("rme_busy", busy, 0);
    chk("rme_ready", word_ready, 1);
    chk("rme_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    word_valid = 1'b1;
    word_data = 32'h0000000A;
    @(negedge clk);
    word_valid = 1'b0;
    chk("rme_restart_wait", byte_valid, 0);
    @(negedge clk);
    emit_word("rme_restart", {"0000000A", 8'h0D, 8'h0A}, 1'b0, 1'b0, 32'h0);
    chk("rme_restart_busy", busy, 0);
    byte_ready = 1'b0;
    word_valid = 1'b1;
    word_data = 32'hA0A1A2A3;
    @(negedge clk);
    word_data = 32'hB4B5B6B7;
    @(negedge clk);
    word_data = 32'hC8C9CACB;
    @(negedge clk);
    word_valid = 1'b0;
    chk("pp_ready", word_ready, 1);
    emit_word("ppA", {"A0A1A2A3", 8'h0D, 8'h0A}, 1'b0, 1'b1, 32'hDCDDDEDF);
    emit_word("ppB", {"B4B5B6B7", 8'h0D, 8'h0A}, 1'b0, 1'b0, 32'h0);
    emit_word("ppC", {"C8C9CACB", 8'h0D, 8'h0A}, 1'b0, 1'b0, 32'h0);
    emit_word("ppD", {"DCDDDEDF", 8'h0D, 8'h0A}, 1'b0, 1'b0, 32'h0);
    chk("pp_end_valid", byte_valid, 0);
    chk("pp_end_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
